// File: rtl/uart_tx_fifo_if.sv
// Write-side valid/ready handshake for uart_tx_fifo.
interface uart_tx_fifo_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] wr_data;
    logic                 wr_valid;
    logic                 wr_ready;

    modport master (output wr_data, output wr_valid, input  wr_ready);
    modport slave  (input  wr_data, input  wr_valid, output wr_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with transmit FIFO; LSB first, back-to-back frames while data is queued.
// Optional parity bit and parity_odd port when UART_TX_PARITY_EN is defined.
module uart_tx_fifo #(
    parameter int CLK_PER_HALF_BIT = 434,
    parameter int DATA_BITS        = 8,
    parameter int STOP_BITS        = 1,
    parameter int FIFO_DEPTH       = 16
) (
    input  logic                          clk,
    input  logic                          rstn,
    uart_tx_fifo_if.slave                 wr,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          tx_busy,
    output logic                          txd
`ifdef UART_TX_PARITY_EN
    ,
    input  logic                          parity_odd
`endif
);
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int CW       = AW + 1;
    localparam int BW       = $clog2(2 * CLK_PER_HALF_BIT);
    localparam int BIT_LAST = 2 * CLK_PER_HALF_BIT - 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state, state_next;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [CW-1:0]        count_next;
    logic [BW-1:0]        bit_cnt;
    logic [3:0]           data_idx;
    logic [1:0]           stop_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 push, pop, bit_end, last_data, last_stop, fifo_nonempty;
`ifdef UART_TX_PARITY_EN
    logic                 par_bit;
`endif

    assign push          = wr.wr_valid && wr.wr_ready;
    assign fifo_nonempty = fifo_count != '0;
    assign bit_end       = bit_cnt == BW'(BIT_LAST);
    assign last_data     = data_idx == 4'(DATA_BITS - 1);
    assign last_stop     = stop_idx == 2'(STOP_BITS - 1);
    // Pop from IDLE, or at the last stop-bit boundary so the next start bit follows with no gap
    assign pop           = fifo_nonempty &&
                           ((state == IDLE) || (state == STOP && bit_end && last_stop));
    assign count_next    = fifo_count + CW'(push) - CW'(pop);

    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (fifo_nonempty) state_next = START;
            START: if (bit_end) state_next = DATA;
`ifdef UART_TX_PARITY_EN
            DATA:   if (bit_end && last_data) state_next = PARITY;
            PARITY: if (bit_end) state_next = STOP;
`else
            DATA:  if (bit_end && last_data) state_next = STOP;
`endif
            STOP:  if (bit_end && last_stop) state_next = fifo_nonempty ? START : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        txd     = 1'b1;
        tx_busy = (state != IDLE) || fifo_nonempty;
        case (state)
            START:  txd = 1'b0;
            DATA:   txd = shift[0];
`ifdef UART_TX_PARITY_EN
            PARITY: txd = par_bit;
`endif
            default: txd = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr.wr_data;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            wr.wr_ready <= 1'b0;
            bit_cnt     <= '0;
            data_idx    <= '0;
            stop_idx    <= '0;
            shift       <= '0;
`ifdef UART_TX_PARITY_EN
            par_bit     <= 1'b0;
`endif
        end else begin
            fifo_count  <= count_next;
            wr.wr_ready <= count_next != CW'(FIFO_DEPTH);
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                shift  <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
                par_bit <= (^mem[rd_ptr]) ^ parity_odd;
`endif
            end
            if (state == IDLE || state_next != state || bit_end) bit_cnt <= '0;
            else                                                 bit_cnt <= bit_cnt + 1'b1;
            if (state != DATA) data_idx <= '0;
            else if (bit_end) begin
                data_idx <= data_idx + 1'b1;
                shift    <= shift >> 1;
            end
            if (state != STOP)  stop_idx <= '0;
            else if (bit_end)   stop_idx <= stop_idx + 1'b1;
        end
    end
endmodule
